bus_router: RTL
===============

// Module: bus_router
// PURPOSE
//  Parametrised memory-mapped bus router between the riscv64 core's bus and N_SLV peripheral slaves (RAM, keyboard, UART, SD, ...).
//  Replaces hand-written per-device address decoding with a table-driven decoder and a registered request/ack handshake.
//  Adds unmapped-address error responses, single-shot write semantics and an optional slave timeout.
// PARAMETERS
//  N_SLV          4        number of slave channels
//  DW             32       slave data width (<=64); read data zero-extended to 64
//  SLV_AW         16       width of slave-relative address offset
//  SLV_BASE       {N_SLV{64'h0}}  packed N_SLV*64 base addresses, channel k at bits [64k+:64]
//  SLV_SIZE       {N_SLV{64'h0}}  packed N_SLV*64 window sizes in bytes; size 0 disables channel
//  TIMEOUT_CYCLES 1024     slave ack timeout (used only with BUS_ROUTER_TIMEOUT_EN)
// PORTS
//  clk              in   1          system clock, single clock domain
//  reset            in   1          asynchronous, active-low reset
//  bus_address      in   64         master byte address
//  bus_write_data   in   64         master write data
//  bus_write_enable in   1          master write request, level, held until done
//  bus_read_enable  in   1          master read request, level, held until done
//  bus_read_data    out  64         read data, valid while bus_read_done=1
//  bus_read_done    out  1          one-cycle read completion pulse
//  bus_write_done   out  1          one-cycle write completion pulse
//  bus_error        out  1          one-cycle, coincident with done: unmapped, conflict or timeout
//  slv_req          out  N_SLV      one-hot request strobe, held until matching ack
//  slv_we           out  1          1=write, 0=read; valid while any slv_req bit set
//  slv_addr         out  SLV_AW     bus_address - SLV_BASE[k], truncated to SLV_AW
//  slv_wdata        out  DW         bus_write_data[DW-1:0]
//  slv_rdata        in   N_SLV*DW   per-slave read data, channel k at [DW*k+:DW]
//  slv_ack          in   N_SLV      per-slave completion, sampled only for the active channel
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction aborts; no done pulse.
//  FSM: IDLE -> REQ -> RESP -> RELEASE -> IDLE.
//  IDLE: if read_enable|write_enable: decode, register channel index, offset, wdata and direction; next REQ.
//   Decode: hit k when SLV_BASE[k] <= addr < SLV_BASE[k]+SLV_SIZE[k]; lowest k wins on overlap.
//   Both enables high: no slave access; error response, both done pulses asserted.
//   No hit: no slave access; next RESP with bus_error=1, bus_read_data=0.
//  REQ: slv_req[k]=1 with stable slv_we/slv_addr/slv_wdata until slv_ack[k]=1 (ack allowed in first REQ cycle).
//   On ack: capture slv_rdata[k] zero-extended; next RESP. Acks on other channels, and acks in any other state, are ignored.
//  RESP: exactly one cycle.
//   Pulse bus_read_done or bus_write_done per direction.
//   bus_read_data holds captured data in this cycle and returns to 0 afterwards.
//   bus_error asserted in this cycle when applicable.
//  RELEASE: wait until both enables are 0, then IDLE. Held enables never re-issue an access; one write per request.
//  Minimum latency: enable sampled cycle 0 -> slv_req cycle 1 -> (ack cycle 1) -> done cycle 2.
//  Address arithmetic: 64-bit unsigned; base+size computed at 65 bits, so a window ending at 2^64 is legal.
//  Back-to-back: new request accepted on the first IDLE cycle after enables were seen low.
// CONFIGURATION
//  BUS_ROUTER_TIMEOUT_EN defined:
//   Counter starts at 0 on REQ entry and increments each REQ cycle without ack.
//   When the count reaches TIMEOUT_CYCLES-1 without ack: drop slv_req; RESP with bus_error=1, read data 0xFFFF_FFFF zero-extended.
//   A late ack in RELEASE or IDLE is ignored.
//  BUS_ROUTER_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  Bases 0x0/0x2000/0x3000/0x4000, sizes 0x2000/0x1000/0x1000/0x10; read 0x2010, slave1 acks same cycle with 0x1234
//   -> slv_req=4'b0010, slv_addr=0x10, bus_read_done at cycle 2, bus_read_data=0x1234, bus_error=0.
//  Write 0x4000 data 0xA5, enable held 20 cycles, slave3 acks after 3 cycles
//   -> exactly one slv_req pulse train, slv_wdata=0xA5, single bus_write_done, no second request until enable drops.
//  Read 0x9000 (unmapped) -> slv_req stays 0; bus_read_done+bus_error at cycle 2; bus_read_data=0.
//  Read and write enables both high at 0x0 -> no slv_req; both done pulses with bus_error=1.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, slave0 never acks -> slv_req drops after 8 REQ cycles; error with data 0xFFFF_FFFF.
//  Reset=0 during REQ -> slv_req and all outputs 0 immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/bus_router.sv
// Table-driven memory-mapped router from the core bus to N_SLV slaves.
// Optional ack timeout enabled by defining BUS_ROUTER_TIMEOUT_EN.
module bus_router #(
    parameter int                   N_SLV          = 4,
    parameter int                   DW             = 32,
    parameter int                   SLV_AW         = 16,
    parameter logic [N_SLV*64-1:0]  SLV_BASE       = '0,
    parameter logic [N_SLV*64-1:0]  SLV_SIZE       = '0,
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         bus_address,
    input  logic [63:0]         bus_write_data,
    input  logic                bus_write_enable,
    input  logic                bus_read_enable,
    output logic [63:0]         bus_read_data,
    output logic                bus_read_done,
    output logic                bus_write_done,
    output logic                bus_error,
    output logic [N_SLV-1:0]    slv_req,
    output logic                slv_we,
    output logic [SLV_AW-1:0]   slv_addr,
    output logic [DW-1:0]       slv_wdata,
    input  logic [N_SLV*DW-1:0] slv_rdata,
    input  logic [N_SLV-1:0]    slv_ack
);

    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     chan_q, chan_d;
    logic [SLV_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [63:0]       rdata_q, rdata_d;

    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic [63:0]       hit_off;
    logic              req_act;
    logic              unused_wdata;

    assign unused_wdata = ^bus_write_data;

`ifdef BUS_ROUTER_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Descending scan so the lowest matching channel wins on overlap
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ({1'b0, bus_address} >= {1'b0, SLV_BASE[64*k +: 64]} &&
                {1'b0, bus_address} <
                {1'b0, SLV_BASE[64*k +: 64]} + {1'b0, SLV_SIZE[64*k +: 64]}) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
                hit_off = bus_address - SLV_BASE[64*k +: 64];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef BUS_ROUTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef BUS_ROUTER_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (bus_read_enable || bus_write_enable) begin
                    rd_d    = bus_read_enable;
                    wr_d    = bus_write_enable;
                    err_d   = (bus_read_enable && bus_write_enable) || !hit;
                    chan_d  = hit_idx;
                    addr_d  = hit_off[SLV_AW-1:0];
                    wdata_d = bus_write_data[DW-1:0];
                    rdata_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A pending error skips the slave and still answers in the next cycle
                if (err_q) begin
                    state_d = RESP;
                end else if (slv_ack[chan_q]) begin
                    if (rd_q) rdata_d = 64'(slv_rdata[int'(chan_q)*DW +: DW]);
                    state_d = RESP;
                end
`ifdef BUS_ROUTER_TIMEOUT_EN
                else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    if (rd_q) rdata_d = 64'h0000_0000_FFFF_FFFF;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            RESP: state_d = RELEASE;
            RELEASE: begin
                if (!bus_read_enable && !bus_write_enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            chan_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef BUS_ROUTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef BUS_ROUTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_act        = (state_q == REQ) && !err_q;
    assign slv_req        = req_act ? (N_SLV'(1) << chan_q) : '0;
    assign slv_we         = req_act && wr_q;
    assign slv_addr       = addr_q;
    assign slv_wdata      = wdata_q;
    assign bus_read_done  = (state_q == RESP) && rd_q;
    assign bus_write_done = (state_q == RESP) && wr_q;
    assign bus_error      = (state_q == RESP) && err_q;
    assign bus_read_data  = (state_q == RESP) ? rdata_q : '0;

endmodule
